// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared op codes, FSM state encoding and small arithmetic helpers for the
// HI/LO multiply/divide controller.
package hilo_mdu_ctrl_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// 32-step radix-2 restoring divider on unsigned magnitudes. The final step's
// quotient/remainder are exposed combinationally alongside done.
module hilo_mdu_ctrl_div_iter
  import hilo_mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_r, quo_r, den_r;
  logic [5:0]  cnt_r;
  logic        busy_r;
  logic [32:0] diff_s;
  logic [31:0] rem_nxt_s, quo_nxt_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    diff_s = {rem_r, quo_r[31]} - {1'b0, den_r};
    if (diff_s[32]) begin
      rem_nxt_s = {rem_r[30:0], quo_r[31]};
      quo_nxt_s = {quo_r[30:0], 1'b0};
    end else begin
      rem_nxt_s = diff_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b1};
    end
  end

  assign done      = busy_r && (cnt_r == 6'd31);
  assign quotient  = quo_nxt_s;
  assign remainder = rem_nxt_s;

  // Iteration state and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r  <= 32'd0;
      quo_r  <= 32'd0;
      den_r  <= 32'd0;
      cnt_r  <= 6'd0;
      busy_r <= 1'b0;
    end else if (start && !busy_r) begin
      rem_r  <= 32'd0;
      quo_r  <= dividend;
      den_r  <= divisor;
      cnt_r  <= 6'd0;
      busy_r <= 1'b1;
    end else if (busy_r && (abort || done)) begin
      cnt_r  <= 6'd0;
      busy_r <= 1'b0;
    end else if (busy_r) begin
      rem_r  <= rem_nxt_s;
      quo_r  <= quo_nxt_s;
      cnt_r  <= cnt_r + 6'd1;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer: runs MULT/MULTU/DIV/DIVU/MTHI/MTLO, stalls EX while
// busy, and issues a single full-width {hi, lo} write per operation.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_cur_i,
  input  logic [31:0] lo_cur_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  mdu_state_e  state_r, state_nxt_s;
  logic        accept_s, is_signed_s, is_div_op_s, mul_last_s;
  logic        stall_s, we_s;
  logic [63:0] a_ext_s, b_ext_s, prod_s, prod_r;
  logic [3:0]  mul_cnt_r;
  logic        div_neg_q_r, div_neg_r_r, div_dz_r;
  logic [31:0] a_r, hi_r, lo_r;
  logic        div_done_s;
  logic [31:0] div_quo_s, div_rem_s, div_hi_s, div_lo_s;

  assign accept_s    = (state_r == ST_IDLE) && start_i && !flush_i;
  assign is_signed_s = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign is_div_op_s = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  // Sign- or zero-extend to 64 bits so the low half of one product serves both.
  assign a_ext_s     = {{32{is_signed_s & a_i[31]}}, a_i};
  assign b_ext_s     = {{32{is_signed_s & b_i[31]}}, b_i};
  assign prod_s      = a_ext_s * b_ext_s;
  assign mul_last_s  = (mul_cnt_r == MUL_LAST);

  hilo_mdu_ctrl_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_s && is_div_op_s),
    .abort     ((state_r == ST_DIV) && flush_i),
    .dividend  (cond_neg(a_i, is_signed_s && a_i[31])),
    .divisor   (cond_neg(b_i, is_signed_s && b_i[31])),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_i)
            MDU_MULT, MDU_MULTU: state_nxt_s = ST_MUL;
            MDU_DIV, MDU_DIVU:   state_nxt_s = ST_DIV;
            default:             state_nxt_s = ST_DONE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush_i)         state_nxt_s = ST_IDLE;
        else if (mul_last_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_MUL;
      end
      ST_DIV: begin
        if (flush_i)         state_nxt_s = ST_IDLE;
        else if (div_done_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_DIV;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stall and write strobe; stall drops in DONE so EX advances with the write.
  always_comb begin
    stall_s = 1'b0;
    we_s    = 1'b0;
    case (state_r)
      ST_IDLE:        stall_s = accept_s;
      ST_MUL, ST_DIV: stall_s = 1'b1;
      ST_DONE:        we_s    = !flush_i;
      default: begin
        stall_s = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // Signed fixup; a zero divisor bypasses it with the fixed {a, all-ones} result.
  always_comb begin
    if (div_dz_r) begin
      div_hi_s = a_r;
      div_lo_s = 32'hFFFF_FFFF;
    end else begin
      div_hi_s = cond_neg(div_rem_s, div_neg_r_r);
      div_lo_s = cond_neg(div_quo_s, div_neg_q_r);
    end
  end

  // Operand capture and result registers; results only load on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r      <= 64'd0;
      mul_cnt_r   <= 4'd0;
      div_neg_q_r <= 1'b0;
      div_neg_r_r <= 1'b0;
      div_dz_r    <= 1'b0;
      a_r         <= 32'd0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
    end else if (accept_s) begin
      prod_r      <= prod_s;
      mul_cnt_r   <= 4'd0;
      div_neg_q_r <= is_signed_s && (a_i[31] ^ b_i[31]);
      div_neg_r_r <= is_signed_s && a_i[31];
      div_dz_r    <= (b_i == 32'd0);
      a_r         <= a_i;
      case (op_i)
        MDU_MTHI: begin
          hi_r <= a_i;
          lo_r <= lo_cur_i;
        end
        MDU_MTLO: begin
          hi_r <= hi_cur_i;
          lo_r <= a_i;
        end
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
        default: begin
          hi_r <= hi_cur_i;
          lo_r <= lo_cur_i;
        end
      endcase
    end else if ((state_r == ST_MUL) && !flush_i) begin
      mul_cnt_r <= mul_cnt_r + 4'd1;
      if (mul_last_s) begin
        hi_r <= prod_r[63:32];
        lo_r <= prod_r[31:0];
      end
    end else if ((state_r == ST_DIV) && !flush_i && div_done_s) begin
      hi_r <= div_hi_s;
      lo_r <= div_lo_s;
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end

  assign stall_o = stall_s;
  assign we_o    = we_s;
  assign hi_o    = hi_r;
  assign lo_o    = lo_r;

endmodule
